// File: rtl/vid_pkg.sv
// Shared types and constants for the consumer-paced video test-pattern source.
// Colours are 3-bit {R,G,B} masks that get widened to full channels in the top.
package vid_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam logic [2:0] COLOR_WHITE   = 3'b111;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_BLACK   = 3'b000;

  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_box_mover.sv
// Bouncing-box position tracker: steps one pixel per axis on each frame strobe.
// Exposes the post-step position so the pixel pipeline can use it in the same cycle.
module vid_box_mover #(
  parameter int HW       = 12,
  parameter int VW       = 11,
  parameter int BOX_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [HW-1:0] width,
  input  logic [VW-1:0] height,
  output logic [HW-1:0] next_x,
  output logic [VW-1:0] next_y
);

  logic [HW-1:0] bx;
  logic [VW-1:0] by;
  logic          dir_x, dir_y, next_dir_x, next_dir_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bx    <= '0;
      by    <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else begin
      bx    <= next_x;
      by    <= next_y;
      dir_x <= next_dir_x;
      dir_y <= next_dir_y;
    end
  end

  // Direction bit 0 means increasing; a blocked move flips and steps back instead.
  always_comb begin
    next_x     = bx;
    next_y     = by;
    next_dir_x = dir_x;
    next_dir_y = dir_y;
    if (step) begin
      if (!dir_x) begin
        if (({1'b0, bx} + (HW+1)'(BOX_SIZE) + (HW+1)'(1)) > {1'b0, width}) begin
          next_dir_x = 1'b1;
          next_x     = bx - HW'(1);
        end else begin
          next_x = bx + HW'(1);
        end
      end else if (bx == '0) begin
        next_dir_x = 1'b0;
        next_x     = bx + HW'(1);
      end else begin
        next_x = bx - HW'(1);
      end

      if (!dir_y) begin
        if (({1'b0, by} + (VW+1)'(BOX_SIZE) + (VW+1)'(1)) > {1'b0, height}) begin
          next_dir_y = 1'b1;
          next_y     = by - VW'(1);
        end else begin
          next_y = by + VW'(1);
        end
      end else if (by == '0) begin
        next_dir_y = 1'b0;
        next_y     = by + VW'(1);
      end else begin
        next_y = by - VW'(1);
      end
    end
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Consumer-paced test-pattern source: the encoder's read/newline/newframe strobes
// walk the position, and o_pixel is registered from the post-strobe position.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int HW             = 12,
  parameter int VW             = 11,
  parameter int CHECK_LOG2     = 5,
  parameter int BOX_SIZE       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [HW-1:0]               i_width,
  input  logic [VW-1:0]               i_height,
  input  logic [1:0]                  i_mode,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [1:0]                  o_mode,
  output logic                        o_overrun
);

  localparam int PW = 3*BITS_PER_COLOR;

  logic [HW-1:0] hpos, hpos_next, width_q, width_next;
  logic [HW-1:0] bar_cnt, bar_cnt_next;
  logic [VW-1:0] vpos, vpos_next, height_q, height_next;
  logic [2:0]    bar_idx, bar_idx_next;
  mode_e         mode_q, mode_next;
  logic          overrun, overrun_next;
  logic [PW-1:0] pixel_next;
  logic [HW-1:0] box_x;
  logic [VW-1:0] box_y;
  logic          in_box;

  function automatic logic [PW-1:0] expand(input logic [2:0] c);
    return {{BITS_PER_COLOR{c[2]}}, {BITS_PER_COLOR{c[1]}}, {BITS_PER_COLOR{c[0]}}};
  endfunction

  vid_box_mover #(
    .HW       (HW),
    .VW       (VW),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk    (clk),
    .rst    (rst),
    .step   (i_newframe),
    .width  (i_width),
    .height (i_height),
    .next_x (box_x),
    .next_y (box_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hpos     <= '0;
      vpos     <= '0;
      width_q  <= HW'(DEFAULT_WIDTH);
      height_q <= VW'(DEFAULT_HEIGHT);
      mode_q   <= MODE_BARS;
      overrun  <= 1'b0;
      bar_idx  <= '0;
      bar_cnt  <= HW'((DEFAULT_WIDTH >> 3) - 1);
      o_pixel  <= '1;
    end else begin
      hpos     <= hpos_next;
      vpos     <= vpos_next;
      width_q  <= width_next;
      height_q <= height_next;
      mode_q   <= mode_next;
      overrun  <= overrun_next;
      bar_idx  <= bar_idx_next;
      bar_cnt  <= bar_cnt_next;
      o_pixel  <= pixel_next;
    end
  end

  // Bar index advances on counter expiry instead of dividing hpos; it sticks at 7
  // so the final bar soaks up any width remainder.
  always_comb begin
    hpos_next    = hpos;
    vpos_next    = vpos;
    width_next   = width_q;
    height_next  = height_q;
    mode_next    = mode_q;
    overrun_next = overrun;
    bar_idx_next = bar_idx;
    bar_cnt_next = bar_cnt;
    if (i_newframe) begin
      hpos_next    = '0;
      vpos_next    = '0;
      width_next   = i_width;
      height_next  = i_height;
      mode_next    = mode_e'(i_mode);
      overrun_next = 1'b0;
      bar_idx_next = '0;
      bar_cnt_next = (i_width >> 3) - HW'(1);
    end else if (i_newline) begin
      hpos_next    = '0;
      bar_idx_next = '0;
      bar_cnt_next = (width_q >> 3) - HW'(1);
      if (vpos < height_q - VW'(1)) begin
        vpos_next = vpos + VW'(1);
      end else begin
        overrun_next = 1'b1;
      end
    end else if (i_rd) begin
      if (hpos < width_q - HW'(1)) begin
        hpos_next = hpos + HW'(1);
        if (bar_cnt == '0) begin
          bar_cnt_next = (width_q >> 3) - HW'(1);
          if (bar_idx != 3'd7) begin
            bar_idx_next = bar_idx + 3'd1;
          end
        end else begin
          bar_cnt_next = bar_cnt - HW'(1);
        end
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_comb begin
    in_box = (hpos_next >= box_x) &&
             ({1'b0, hpos_next} < ({1'b0, box_x} + (HW+1)'(BOX_SIZE))) &&
             (vpos_next >= box_y) &&
             ({1'b0, vpos_next} < ({1'b0, box_y} + (VW+1)'(BOX_SIZE)));
    pixel_next = '0;
    case (mode_next)
      MODE_BARS:  pixel_next = expand(bar_color(bar_idx_next));
      MODE_CHECK: pixel_next = (hpos_next[CHECK_LOG2] ^ vpos_next[CHECK_LOG2]) ?
                               expand(COLOR_BLACK) : expand(COLOR_WHITE);
      MODE_GRAD:  pixel_next = {BITS_PER_COLOR'(hpos_next),
                                BITS_PER_COLOR'(vpos_next),
                                BITS_PER_COLOR'(BITS_PER_COLOR'(hpos_next) +
                                                BITS_PER_COLOR'(vpos_next))};
      MODE_BOX:   pixel_next = in_box ? expand(COLOR_WHITE) : expand(COLOR_BLACK);
      default:    pixel_next = '0;
    endcase
  end

  assign o_mode    = mode_q;
  assign o_overrun = overrun;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen: walks the position with strobes and compares
// pixels, mode and overrun against hand-computed values.
module tb_vid_pattern_gen;

  logic        clk;
  logic        rst;
  logic [11:0] i_width;
  logic [10:0] i_height;
  logic [1:0]  i_mode;
  logic        i_rd, i_newline, i_newframe;
  logic [23:0] o_pixel;
  logic [1:0]  o_mode;
  logic        o_overrun;

  int test_count = 0;
  int fail_count = 0;
  int tb_h = 0;
  int tb_v = 0;

  vid_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .i_width    (i_width),
    .i_height   (i_height),
    .i_mode     (i_mode),
    .i_rd       (i_rd),
    .i_newline  (i_newline),
    .i_newframe (i_newframe),
    .o_pixel    (o_pixel),
    .o_mode     (o_mode),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic nf, input logic nl, input logic rd);
    i_newframe = nf;
    i_newline  = nl;
    i_rd       = rd;
    @(posedge clk);
    #1;
    i_newframe = 1'b0;
    i_newline  = 1'b0;
    i_rd       = 1'b0;
  endtask

  task automatic new_frame(input int w, input int h, input int m);
    i_width  = 12'(w);
    i_height = 11'(h);
    i_mode   = 2'(m);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tb_h = 0;
    tb_v = 0;
  endtask

  task automatic lines_to(input int v);
    while (tb_v < v) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tb_h = 0;
      tb_v++;
    end
  endtask

  task automatic read_to(input int h);
    while (tb_h < h) begin
      apply_stimulus(1'b0, 1'b0, 1'b1);
      tb_h++;
    end
  endtask

  initial begin
    rst = 1'b0;
    i_width = 12'd0; i_height = 11'd0; i_mode = 2'd0;
    i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_pixel", 32'(o_pixel), 32'hFFFFFF);
    check_output("reset_mode", 32'(o_mode), 32'd0);
    check_output("reset_overrun", 32'(o_overrun), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    new_frame(640, 480, 0);
    check_output("bars_h0", 32'(o_pixel), 32'hFFFFFF);
    read_to(79);  check_output("bars_h79", 32'(o_pixel), 32'hFFFFFF);
    read_to(80);  check_output("bars_h80", 32'(o_pixel), 32'hFFFF00);
    read_to(160); check_output("bars_h160", 32'(o_pixel), 32'h00FFFF);
    read_to(400); check_output("bars_h400", 32'(o_pixel), 32'hFF0000);
    read_to(560); check_output("bars_h560", 32'(o_pixel), 32'h000000);
    read_to(639); check_output("bars_h639", 32'(o_pixel), 32'h000000);
    check_output("no_overrun", 32'(o_overrun), 32'd0);

    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("hold_pixel", 32'(o_pixel), 32'h000000);
    check_output("overrun_set", 32'(o_overrun), 32'd1);

    i_mode = 2'd1;
    lines_to(1);
    check_output("overrun_sticky", 32'(o_overrun), 32'd1);
    check_output("newline_pixel", 32'(o_pixel), 32'hFFFFFF);
    check_output("mode_midframe", 32'(o_mode), 32'd0);

    i_width = 12'd640; i_height = 11'd480; i_mode = 2'd2;
    apply_stimulus(1'b1, 1'b0, 1'b1);
    tb_h = 0; tb_v = 0;
    check_output("nf_rd_pixel", 32'(o_pixel), 32'h000000);
    check_output("nf_mode", 32'(o_mode), 32'd2);
    check_output("nf_overrun_clr", 32'(o_overrun), 32'd0);

    new_frame(100, 480, 0);
    read_to(83); check_output("w100_h83", 32'(o_pixel), 32'h0000FF);
    read_to(84); check_output("w100_h84", 32'(o_pixel), 32'h000000);
    read_to(99); check_output("w100_h99", 32'(o_pixel), 32'h000000);

    new_frame(640, 480, 1);
    read_to(31); check_output("chk_31_0", 32'(o_pixel), 32'hFFFFFF);
    read_to(32); check_output("chk_32_0", 32'(o_pixel), 32'h000000);
    lines_to(32);
    check_output("chk_0_32", 32'(o_pixel), 32'h000000);
    read_to(32); check_output("chk_32_32", 32'(o_pixel), 32'hFFFFFF);

    new_frame(640, 480, 2);
    lines_to(10);
    read_to(300); check_output("grad_300_10", 32'(o_pixel), 32'h2C0A36);

    #2;
    rst = 1'b0;
    #1;
    check_output("midreset_pixel", 32'(o_pixel), 32'hFFFFFF);
    check_output("midreset_mode", 32'(o_mode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int f = 0; f < 32; f++) new_frame(64, 48, 3);
    read_to(31); check_output("box32_31_0", 32'(o_pixel), 32'h000000);
    read_to(32); check_output("box32_32_0", 32'(o_pixel), 32'hFFFFFF);
    lines_to(31);
    read_to(63); check_output("box32_63_31", 32'(o_pixel), 32'hFFFFFF);
    lines_to(32);
    read_to(63); check_output("box32_63_32", 32'(o_pixel), 32'h000000);

    for (int f = 0; f < 8; f++) new_frame(64, 48, 3);
    lines_to(7);
    read_to(24); check_output("box40_24_7", 32'(o_pixel), 32'h000000);
    lines_to(8);
    read_to(23); check_output("box40_23_8", 32'(o_pixel), 32'h000000);
    read_to(24); check_output("box40_24_8", 32'(o_pixel), 32'hFFFFFF);
    read_to(55); check_output("box40_55_8", 32'(o_pixel), 32'hFFFFFF);
    read_to(56); check_output("box40_56_8", 32'(o_pixel), 32'h000000);
    lines_to(39);
    read_to(24); check_output("box40_24_39", 32'(o_pixel), 32'hFFFFFF);
    lines_to(40);
    read_to(24); check_output("box40_24_40", 32'(o_pixel), 32'h000000);
    check_output("box_mode", 32'(o_mode), 32'd3);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/vid_pattern_gen.md
Name: vid_pattern_gen

Overview:
- Parametrised successor to the fixed single-pattern test source feeding the HDMI encoder.
- Consumer-paced pixel source. The downstream encoder drives the read/newline/newframe strobes.
- Four selectable patterns: colour bars, checkerboard, gradient, bouncing box. Runtime resolution and a per-frame overrun flag are included.
- Sits between the pixel-clock domain of the TMDS encoder and any future framebuffer mux.

Parameters:
- BITS_PER_COLOR, 8, bits per colour channel; o_pixel is 3*BITS_PER_COLOR wide, ordered R,G,B MSB-first.
- HW, 12, width of the horizontal position counter and i_width.
- VW, 11, width of the vertical position counter and i_height.
- CHECK_LOG2, 5, checkerboard square edge is 2^CHECK_LOG2 pixels.
- BOX_SIZE, 32, edge length of the bouncing box in pixels.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-low reset.
- i_width, input, HW, active pixels per line; sampled at newframe; legal range 8..2^HW-1, and greater than BOX_SIZE for mode 3.
- i_height, input, VW, active lines per frame; sampled at newframe; legal range greater than BOX_SIZE.
- i_mode, input, 2, pattern request; sampled at newframe.
- i_rd, input, 1, consumer took the current pixel.
- i_newline, input, 1, start of the next line.
- i_newframe, input, 1, start of a new frame.
- o_pixel, output, 3*BITS_PER_COLOR, pixel at the current (hpos,vpos).
- o_mode, output, 2, pattern active this frame.
- o_overrun, output, 1, sticky flag: a read or newline went past the frame bounds.

Behaviour:
- Reset (rst low, asynchronous):
  - hpos=0, vpos=0, o_mode=0.
  - Latched width/height are 640/480.
  - Box position (0,0), box direction +x,+y, bar counter loaded for 640.
  - o_overrun=0, o_pixel=all-ones (bar 0, white).
- State update priority per cycle: i_newframe > i_newline > i_rd. Lower-priority strobes in the same cycle are ignored.
- i_newframe:
  - hpos=0, vpos=0.
  - Latch i_width, i_height, i_mode into o_mode.
  - o_overrun cleared.
  - Box steps once (see mode 3).
- i_newline:
  - hpos=0, bar counter reloaded.
  - vpos+1 if vpos<height-1; otherwise vpos holds and o_overrun is set.
- i_rd:
  - hpos+1 if hpos<width-1; otherwise hpos holds and o_overrun is set.
- o_pixel timing:
  - o_pixel is registered and computed from the next-state position.
  - In every cycle o_pixel matches the registered hpos/vpos.
  - The pixel following a read appears on the clock edge that consumed i_rd (0 cycles relative to position, 1 clock after the strobe).
- Mode 0, colour bars:
  - barw = width>>3.
  - A down-counter tracks position within the bar. Bar index b increments when the counter expires and saturates at 7, so the last bar absorbs the remainder.
  - No divider is used.
  - Each channel is all-ones or zero: R=!b[1], G=!b[2], B=!b[0].
  - Resulting sequence: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 1, checkerboard: white when hpos[CHECK_LOG2]^vpos[CHECK_LOG2]==0, else black.
- Mode 2, gradient:
  - R=hpos[BITS_PER_COLOR-1:0], G=vpos low bits.
  - B=(hpos+vpos) low bits; the sum is truncated, wrap is intended.
  - Position counters narrower than BITS_PER_COLOR are zero-extended.
- Mode 3, bouncing box:
  - White when bx<=hpos<bx+BOX_SIZE and by<=vpos<by+BOX_SIZE, else black.
  - At each newframe each axis moves 1 pixel in its direction.
  - If a move would put bx+BOX_SIZE past width, or bx below 0, the direction for that axis flips and the move is taken in the new direction. The y axis uses height the same way.
  - The box never leaves the frame.
- A mode change takes effect only at newframe; a mid-frame change to i_mode has no effect.
- Reset mid-frame returns to the reset state immediately. The first newframe after reset latches the new geometry.

Decomposition:
- Package vid_pkg:
  - mode enum MODE_BARS=0, MODE_CHECK=1, MODE_GRAD=2, MODE_BOX=3.
  - 3-bit colour constants for the eight bar colours.
  - Defaults 640/480.
- One sub-module, vid_box_mover: holds bx, by and the direction bits, steps on a frame strobe, and takes width, height and BOX_SIZE.
- Bar counter and position counters stay in the top.

Test Plan:
- Reset, newframe with width=640, height=480, mode=0; 640 reads -> pixel is FFFFFF for hpos 0..79, FFFF00 at hpos 80, 000000 at hpos 560..639; o_overrun=0.
- Width=100 in mode 0 -> barw=12; hpos 84..99 all black (bar 7 absorbs remainder).
- Mode 1 -> hpos 31 vpos 0 = FFFFFF; hpos 32 vpos 0 = 000000; hpos 32 vpos 32 = FFFFFF.
- Mode 2 -> hpos 300 vpos 10 = 2C0A36 (hex; blue = 310 mod 256 = 0x36, sum truncated).
- Mode 3 with width=64, height=48, 40 newframes -> bx runs 0→32 then back to 24; by runs 0→16→0→8; box pixels never outside the frame.
- 641st read on a 640-wide line -> hpos holds at 639, o_overrun=1; it stays set until newframe clears it. Newframe and i_rd in the same cycle -> hpos=0. i_mode changed mid-frame -> o_mode unchanged until the next newframe.
